// File: rtl/jump_conditioner.sv
// Push-button conditioner and control-state register for the mode-control path.
// Synchronizes and debounces Btn_Raw into Jump, registers Next_State, and emits edge strobes.
module jump_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Btn_Raw,
    input  logic [1:0] Next_State,
    output logic       Jump,
    output logic [1:0] Now_State,
    output logic       Press_Pulse,
    output logic       Release_Pulse,
    output logic       State_Chg
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             jump_q;
    logic [1:0]       state_q;

    // Any sample equal to the current level restarts the count, so bounces only delay Jump.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            Jump  <= 1'b0;
        end else begin
            sync1 <= Btn_Raw;
            sync2 <= sync1;
            if (sync2 == Jump) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                Jump <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // The decoder loop closes through Now_State only; strobes compare against one-cycle-old copies.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Now_State     <= 2'b00;
            state_q       <= 2'b00;
            jump_q        <= 1'b0;
            Press_Pulse   <= 1'b0;
            Release_Pulse <= 1'b0;
            State_Chg     <= 1'b0;
        end else begin
            Now_State     <= Next_State;
            state_q       <= Now_State;
            jump_q        <= Jump;
            Press_Pulse   <= Jump & ~jump_q;
            Release_Pulse <= ~Jump & jump_q;
            State_Chg     <= (Now_State != state_q);
        end
    end

endmodule

// File: tb/tb_jump_conditioner.sv
// Bench for jump_conditioner: directed scenarios push timed expected events; a monitor pops and compares.
module tb_jump_conditioner;

    localparam int DB      = 4;
    localparam int K_JUMP  = 1;
    localparam int K_PRESS = 2;
    localparam int K_REL   = 3;
    localparam int K_STATE = 4;
    localparam int K_CHG   = 5;

    logic       Clock;
    logic       Reset_n;
    logic       Btn_Raw;
    logic [1:0] Next_State;
    logic       Jump;
    logic [1:0] Now_State;
    logic       Press_Pulse;
    logic       Release_Pulse;
    logic       State_Chg;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          t0          = 0;
    logic [15:0] exp_q[$];
    logic        ns_ovr;
    logic [1:0]  ns_force;
    logic        pj;
    logic [1:0]  ps;

    jump_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Btn_Raw      (Btn_Raw),
        .Next_State   (Next_State),
        .Jump         (Jump),
        .Now_State    (Now_State),
        .Press_Pulse  (Press_Pulse),
        .Release_Pulse(Release_Pulse),
        .State_Chg    (State_Chg)
    );

    // clock / cycle counter
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // reference next-state decoder closing the loop
    function automatic logic [1:0] dec(input logic [1:0] s, input logic j);
        case (s)
            2'b00:   dec = j ? 2'b01 : 2'b00;
            2'b01:   dec = j ? 2'b10 : 2'b00;
            2'b10:   dec = j ? 2'b10 : 2'b11;
            default: dec = j ? 2'b10 : 2'b00;
        endcase
    endfunction

    always_comb Next_State = ns_ovr ? ns_force : dec(Now_State, Jump);

    task automatic expect_ev(input int rel, input int kind, input int val);
        exp_q.push_back({rel[7:0], kind[3:0], val[3:0]});
    endtask

    task automatic check_ev(input int rel, input int kind, input int val);
        logic [15:0] got;
        logic [15:0] want;
        got = {rel[7:0], kind[3:0], val[3:0]};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: got rel=%0d kind=%0d val=%0d, required none", rel, kind, val);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                miscompares++;
                $display("FAIL event: got rel=%0d kind=%0d val=%0d, required rel=%0d kind=%0d val=%0d",
                         rel, kind, val, want[15:8], want[7:4], want[3:0]);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic drain(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected events never seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_jump"},    {3'b0, Jump},          4'd0);
        check_val({tag, "_state"},   {2'b0, Now_State},     4'd0);
        check_val({tag, "_press"},   {3'b0, Press_Pulse},   4'd0);
        check_val({tag, "_release"}, {3'b0, Release_Pulse}, 4'd0);
        check_val({tag, "_chg"},     {3'b0, State_Chg},     4'd0);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // monitor: every observed output event is checked against the expected queue
    always @(posedge Clock) begin
        #1;
        if (!Reset_n) begin
            pj = Jump;
            ps = Now_State;
        end else begin
            if (Jump != pj)        check_ev(cyc - t0, K_JUMP, int'(Jump));
            if (Press_Pulse)       check_ev(cyc - t0, K_PRESS, 0);
            if (Release_Pulse)     check_ev(cyc - t0, K_REL, 0);
            if (Now_State != ps)   check_ev(cyc - t0, K_STATE, int'(Now_State));
            if (State_Chg)         check_ev(cyc - t0, K_CHG, 0);
            pj = Jump;
            ps = Now_State;
        end
    end

    initial begin
        Reset_n  = 1'b1;
        Btn_Raw  = 1'b1;
        ns_ovr   = 1'b1;
        ns_force = 2'b00;
        pj       = 1'b0;
        ps       = 2'b00;

        // reset with button already held: async clear, then fresh press
        #1 Reset_n = 1'b0;
        #2 check_reset("async_reset");
        wait_cyc(3);
        check_reset("held_reset");
        expect_ev(6, K_JUMP, 1);
        expect_ev(7, K_PRESS, 0);
        t0 = cyc;
        Reset_n = 1'b1;
        wait_cyc(10);
        drain("reset_press");

        expect_ev(6, K_JUMP, 0);
        expect_ev(7, K_REL, 0);
        t0 = cyc;
        Btn_Raw = 1'b0;
        wait_cyc(10);
        drain("clean_release");

        // bounce: toggling every 2 cycles must not move Jump
        for (int i = 0; i < 10; i++) begin
            Btn_Raw = (i % 2 == 0);
            wait_cyc(2);
        end
        expect_ev(6, K_JUMP, 1);
        expect_ev(7, K_PRESS, 0);
        t0 = cyc;
        Btn_Raw = 1'b1;
        wait_cyc(10);
        drain("bounce_press");
        expect_ev(6, K_JUMP, 0);
        expect_ev(7, K_REL, 0);
        t0 = cyc;
        Btn_Raw = 1'b0;
        wait_cyc(10);
        drain("bounce_release");

        // closed loop through the reference decoder
        ns_ovr = 1'b0;
        expect_ev(6, K_JUMP, 1);
        expect_ev(7, K_PRESS, 0);
        expect_ev(7, K_STATE, 1);
        expect_ev(8, K_STATE, 2);
        expect_ev(8, K_CHG, 0);
        expect_ev(9, K_CHG, 0);
        t0 = cyc;
        Btn_Raw = 1'b1;
        wait_cyc(12);
        drain("loop_press");
        expect_ev(6, K_JUMP, 0);
        expect_ev(7, K_REL, 0);
        expect_ev(7, K_STATE, 3);
        expect_ev(8, K_STATE, 0);
        expect_ev(8, K_CHG, 0);
        expect_ev(9, K_CHG, 0);
        t0 = cyc;
        Btn_Raw = 1'b0;
        wait_cyc(12);
        drain("loop_release");

        // re-press while in 11: must go to 10, never 00
        ns_ovr   = 1'b1;
        ns_force = 2'b11;
        expect_ev(1, K_STATE, 3);
        expect_ev(2, K_CHG, 0);
        t0 = cyc;
        wait_cyc(4);
        drain("enter_11");
        expect_ev(6, K_JUMP, 1);
        expect_ev(7, K_PRESS, 0);
        expect_ev(9, K_STATE, 2);
        expect_ev(10, K_CHG, 0);
        t0 = cyc;
        Btn_Raw = 1'b1;
        wait_cyc(8);
        ns_ovr = 1'b0;
        wait_cyc(6);
        drain("repress_11");
        expect_ev(6, K_JUMP, 0);
        expect_ev(7, K_REL, 0);
        expect_ev(7, K_STATE, 3);
        expect_ev(8, K_STATE, 0);
        expect_ev(8, K_CHG, 0);
        expect_ev(9, K_CHG, 0);
        t0 = cyc;
        Btn_Raw = 1'b0;
        wait_cyc(12);
        drain("repress_release");

        // async reset mid-debounce (cnt=2, state 10); count must restart
        ns_ovr   = 1'b1;
        ns_force = 2'b10;
        expect_ev(1, K_STATE, 2);
        expect_ev(2, K_CHG, 0);
        t0 = cyc;
        wait_cyc(4);
        drain("enter_10");
        t0 = cyc;
        Btn_Raw = 1'b1;
        wait_cyc(4);
        #2 Reset_n = 1'b0;
        #1 check_reset("mid_reset");
        ns_force = 2'b00;
        wait_cyc(2);
        expect_ev(6, K_JUMP, 1);
        expect_ev(7, K_PRESS, 0);
        t0 = cyc;
        Reset_n = 1'b1;
        wait_cyc(10);
        drain("restart_press");
        expect_ev(6, K_JUMP, 0);
        expect_ev(7, K_REL, 0);
        t0 = cyc;
        Btn_Raw = 1'b0;
        wait_cyc(10);
        drain("restart_release");

        // constant Next_State: one change, one strobe
        ns_force = 2'b01;
        expect_ev(1, K_STATE, 1);
        expect_ev(2, K_CHG, 0);
        t0 = cyc;
        wait_cyc(10);
        drain("const_01");
        ns_force = 2'b00;
        expect_ev(1, K_STATE, 0);
        expect_ev(2, K_CHG, 0);
        t0 = cyc;
        wait_cyc(6);
        drain("back_00");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jump_conditioner.md
# jump_conditioner

Front end of the mode-control path. Conditions the raw user push-button into the clean `Jump` level consumed by the combinational next-state decoder, and holds the 2-bit control-state register that feeds `Now_State` to that decoder and captures its `Next_State`. It also emits single-cycle press, release and state-change strobes for the drawing, recognition and display stages.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples required before `Jump` changes. Legal range is ≥1. Use 4 in simulation.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`, minimum 1: width of the debounce counter.

Ports (one clock; reset is asynchronous and active-low):
- `Clock` in 1: system clock; all flops are rising-edge.
- `Reset_n` in 1: asynchronous active-low reset.
- `Btn_Raw` in 1: raw, asynchronous, bouncing button input.
- `Next_State` in 2: next state from the external decoder.
- `Jump` out 1: debounced button level; registered.
- `Now_State` out 2: current control state; registered.
- `Press_Pulse` out 1: one-cycle strobe when `Jump` goes 0→1.
- `Release_Pulse` out 1: one-cycle strobe when `Jump` goes 1→0.
- `State_Chg` out 1: one-cycle strobe when `Now_State` takes a different value.

## Operation
- **Synchronizer:** two flops, `sync1 <= Btn_Raw`, `sync2 <= sync1`. Only `sync2` is used downstream.
- **Debounce, per rising edge:**
  - If `sync2 == Jump`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `Jump <= sync2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - The counter never wraps, because it is cleared at the terminal value.
- **Glitch rejection:** any sample that equals `Jump` restarts the count. A bounce therefore delays the `Jump` change but never causes it.
- **State register:** `Now_State <= Next_State` on every edge. The loop `Now_State` → decoder → `Next_State` is closed through this register only; there is no combinational path from `Next_State` to any output.
- **Decoder behaviour the register must support:** `00 -J-> 01 -J-> 10`; `10` holds while J=1; `10 -!J-> 11`; `11 -J-> 10`; `11 -!J-> 00`; `01 -!J-> 00`.
- **Strobes:**
  - `Press_Pulse` and `Release_Pulse` are registered. They are asserted in the cycle immediately after `Jump` changes, for exactly one cycle.
  - `State_Chg` is registered. It is asserted for one cycle after any edge at which `Now_State` loaded a value different from its previous value.
  - Press and release cannot occur in the same cycle.
- **Reset:** all flops clear asynchronously on `Reset_n`=0, with no clock needed: `sync1`, `sync2`, `cnt`, `Jump`=0, `Now_State`=00, and all strobes 0. A debounce in progress is discarded.
- **After reset release:** if `Btn_Raw` is already 1, it is treated as a fresh press. `Jump` rises after the full debounce latency and `Press_Pulse` fires.

## Timing
- Let edge k be the first edge at which `sync1` samples the new `Btn_Raw` value, and assume no bounce:
  - `sync2` updates at edge k+1.
  - The first compare occurs at edge k+2.
  - `Jump` updates at edge k+DEBOUNCE_CYCLES+1.
  - `Press_Pulse` or `Release_Pulse` is high during the cycle after edge k+DEBOUNCE_CYCLES+2.
- **Hold-off at DEBOUNCE_CYCLES=1:** `Jump` follows `sync2` with one cycle of delay. This is the minimum hold-off.
- **State register:** `Now_State` reflects `Next_State` one edge later. `State_Chg` rises one edge after that.
- **Reset:** outputs go to their reset values within the same cycle as `Reset_n` falls (asynchronous). The first functional edge is the first rising edge with `Reset_n`=1.
- **Simultaneous events:** a `Jump` update and a `Now_State` update at the same edge are independent. The decoder sees the new `Jump` on the following edge.

## Test plan
DEBOUNCE_CYCLES=4 in all scenarios.
- **Reset:** `Reset_n`=0, `Btn_Raw`=1, clock running → `Jump`=0, `Now_State`=00, all strobes 0. Release reset at edge 0 → `Jump`=1 after edge 5, `Press_Pulse` high for exactly the cycle after edge 6.
- **Bounce rejection:** `Btn_Raw` toggles every 2 cycles for 20 cycles, then is held 1 → `Jump` stays 0 during the toggling. `Jump` rises 5 edges after the last sync1 sample of 1. Exactly one `Press_Pulse`.
- **Loop with reference decoder model:** clean press held 12 cycles, then released → `Now_State` goes 00→01→10, holds 10, then →11→00. `State_Chg` pulses exactly 4 times. One `Press_Pulse` and one `Release_Pulse`.
- **Re-press in 11:** release, then press again while `Now_State`=11 → `Now_State` goes 11→10 and does not reach 00.
- **Async reset mid-operation:** `Reset_n` low mid-debounce with `cnt`=2 and `Now_State`=10 → all flops clear immediately. After release, the count restarts from 0.
- **Constant `Next_State`:** drive `Next_State`=01 for 10 cycles → `Now_State`=01 after 1 edge, a single `State_Chg` pulse, then `State_Chg`=0.
